// File: rtl/apb_req_arbiter.sv
// apb_req_arbiter
//   Two-requester round-robin arbiter in front of an APB master bridge.
//   A granted requester's command is latched into the bridge outputs, the
//   bridge runs the APB transfer, and a one-cycle ack (with err and rdata)
//   is returned to the requester that was granted.
//
// Parameters
//   TIMEOUT            max BUSY cycles without completion before abort (2..255)
//
// Ports
//   PCLK               clock, all state changes on rising edge
//   PRESET             asynchronous active-high reset
//   req0/req1          level requests, held until ack
//   rw0/rw1            command direction (1 = read)
//   addr0/addr1        9-bit target address (bit 8 selects slave 2)
//   wdata0/wdata1      write data
//   ack0/ack1          one-cycle completion pulse to the granted requester
//   rdata              read data, valid with ack
//   err                completion status (slave error or timeout), valid with ack
//   transfer           transfer enable to the bridge
//   READ_WRITE         direction to the bridge (1 = read)
//   apb_write_paddr    bridge write address
//   apb_read_paddr     bridge read address
//   apb_write_data     bridge write data
//   PREADY/PSLVERR     APB slave ready / error as seen by the bridge
//   apb_read_data_out  read data returned by the bridge
module apb_req_arbiter #(
    parameter int TIMEOUT = 15
) (
    input  logic       PCLK,
    input  logic       PRESET,
    input  logic       req0,
    input  logic       req1,
    input  logic       rw0,
    input  logic       rw1,
    input  logic [8:0] addr0,
    input  logic [8:0] addr1,
    input  logic [7:0] wdata0,
    input  logic [7:0] wdata1,
    output logic       ack0,
    output logic       ack1,
    output logic [7:0] rdata,
    output logic       err,
    output logic       transfer,
    output logic       READ_WRITE,
    output logic [8:0] apb_write_paddr,
    output logic [8:0] apb_read_paddr,
    output logic [7:0] apb_write_data,
    input  logic       PREADY,
    input  logic       PSLVERR,
    input  logic [7:0] apb_read_data_out
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    // Counter value of the final BUSY cycle; the transfer is aborted at the
    // end of that cycle, giving exactly TIMEOUT BUSY cycles in total.
    localparam logic [7:0] LAST_BUSY = 8'(TIMEOUT - 1);

    state_t     state;
    logic [7:0] busy_cnt;
    logic       last_grant;
    logic       grant_id;

    logic       sel_grant;
    logic       sel_rw;
    logic [8:0] sel_addr;
    logic [7:0] sel_wdata;

    // Round-robin pick: on a tie the requester not granted last wins,
    // otherwise whichever single requester is active. The selected
    // command is muxed here so the IDLE branch can latch it directly.
    always_comb begin
        sel_grant = 1'b0;
        if (req0 && req1) begin
            sel_grant = ~last_grant;
        end else begin
            sel_grant = req1;
        end
        sel_rw    = sel_grant ? rw1    : rw0;
        sel_addr  = sel_grant ? addr1  : addr0;
        sel_wdata = sel_grant ? wdata1 : wdata0;
    end

    // Main FSM. Every output is a register updated alongside the state,
    // so the bridge outputs double as the latched command during BUSY.
    // The counter is zero in the first BUSY cycle, which is the bridge
    // SETUP phase, so PREADY/PSLVERR are only honoured once it is nonzero.
    always_ff @(posedge PCLK or posedge PRESET) begin
        if (PRESET) begin
            state           <= IDLE;
            busy_cnt        <= 8'd0;
            last_grant      <= 1'b1;
            grant_id        <= 1'b0;
            ack0            <= 1'b0;
            ack1            <= 1'b0;
            rdata           <= 8'd0;
            err             <= 1'b0;
            transfer        <= 1'b0;
            READ_WRITE      <= 1'b0;
            apb_write_paddr <= 9'd0;
            apb_read_paddr  <= 9'd0;
            apb_write_data  <= 8'd0;
        end else begin
            case (state)
                IDLE: begin
                    ack0  <= 1'b0;
                    ack1  <= 1'b0;
                    rdata <= 8'd0;
                    err   <= 1'b0;
                    if (req0 || req1) begin
                        grant_id        <= sel_grant;
                        last_grant      <= sel_grant;
                        busy_cnt        <= 8'd0;
                        transfer        <= 1'b1;
                        READ_WRITE      <= sel_rw;
                        apb_read_paddr  <= sel_rw ? sel_addr : 9'd0;
                        apb_write_paddr <= sel_rw ? 9'd0 : sel_addr;
                        apb_write_data  <= sel_rw ? 8'd0 : sel_wdata;
                        state           <= BUSY;
                    end
                end

                BUSY: begin
                    busy_cnt <= busy_cnt + 8'd1;
                    if ((busy_cnt != 8'd0 && (PSLVERR || PREADY)) ||
                        busy_cnt == LAST_BUSY) begin
                        state           <= DONE;
                        transfer        <= 1'b0;
                        READ_WRITE      <= 1'b0;
                        apb_read_paddr  <= 9'd0;
                        apb_write_paddr <= 9'd0;
                        apb_write_data  <= 8'd0;
                        ack0            <= ~grant_id;
                        ack1            <= grant_id;
                        // Slave error wins over PREADY; a timeout is only
                        // reached when neither completion condition held.
                        if (busy_cnt != 8'd0 && PSLVERR) begin
                            err   <= 1'b1;
                            rdata <= 8'd0;
                        end else if (busy_cnt != 8'd0 && PREADY) begin
                            err   <= 1'b0;
                            rdata <= READ_WRITE ? apb_read_data_out : 8'd0;
                        end else begin
                            err   <= 1'b1;
                            rdata <= 8'd0;
                        end
                    end
                end

                DONE: begin
                    ack0  <= 1'b0;
                    ack1  <= 1'b0;
                    rdata <= 8'd0;
                    err   <= 1'b0;
                    state <= IDLE;
                end

                default: begin
                    state    <= IDLE;
                    transfer <= 1'b0;
                    ack0     <= 1'b0;
                    ack1     <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: doc/apb_req_arbiter.md
APB_REQ_ARBITER -- requirements
Module: apb_req_arbiter

Interface
REQ-001 SHALL have parameter TIMEOUT, default 15, giving the maximum BUSY cycles without completion before the transfer is aborted with error (legal range 2..255).
REQ-002 SHALL have port PCLK, input, 1, the single clock; all state updates on its rising edge.
REQ-003 SHALL have port PRESET, input, 1, asynchronous active-high reset.
REQ-004 SHALL have ports req0/req1, input, 1 each, a level request held by the requester until its ack.
REQ-005 SHALL have ports rw0/rw1, input, 1 each, command direction: 1 = read, 0 = write.
REQ-006 SHALL have ports addr0/addr1, input, 9 each, target address; bit 8 selects slave 2.
REQ-007 SHALL have ports wdata0/wdata1, input, 8 each, write data.
REQ-008 SHALL have ports ack0/ack1, output, 1 each, a one-cycle completion pulse to the granted requester.
REQ-009 SHALL have port rdata, output, 8, read data, valid only while ack0/ack1 is high.
REQ-010 SHALL have port err, output, 1, completion status (1 = slave error or timeout), valid only with ack.
REQ-011 SHALL have port transfer, output, 1, transfer enable to the APB master bridge.
REQ-012 SHALL have port READ_WRITE, output, 1, direction to the bridge (1 = read).
REQ-013 SHALL have ports apb_write_paddr/apb_read_paddr, output, 9 each, bridge addresses.
REQ-014 SHALL have port apb_write_data, output, 8, bridge write data.
REQ-015 SHALL have ports PREADY/PSLVERR, input, 1 each, the APB slave-ready and error seen by the bridge.
REQ-016 SHALL have port apb_read_data_out, input, 8, read data returned by the bridge.

Function
REQ-017 SHALL implement states IDLE, BUSY and DONE, with all outputs registered.
REQ-018 IDLE: transfer=0; if any req is high, SHALL grant, latch that requester's rw/addr/wdata, and go to BUSY next cycle.
REQ-019 SHALL arbitrate round-robin: on simultaneous req0 and req1, grant the requester not granted last; a lone request is granted immediately.
REQ-020 SHALL, in BUSY, hold transfer=1 and READ_WRITE = latched rw. For a read, apb_read_paddr = latched addr and apb_write_paddr = 0. For a write, apb_write_paddr = latched addr, apb_write_data = latched wdata, and apb_read_paddr = 0.
REQ-021 SHALL keep an 8-bit BUSY cycle counter, cleared on entry to BUSY and incremented each BUSY cycle.
REQ-022 SHALL ignore PREADY and PSLVERR in the first BUSY cycle (counter = 0), which covers the bridge SETUP phase.
REQ-023 In BUSY with counter >= 1, PSLVERR=1 SHALL go to DONE with err=1 and rdata=0; PSLVERR has priority over PREADY.
REQ-024 In BUSY with counter >= 1, PREADY=1 and PSLVERR=0 SHALL go to DONE with err=0, and with rdata = apb_read_data_out for a read or 0 for a write.
REQ-025 SHALL go to DONE with err=1 and rdata=0 when the counter reaches TIMEOUT with no completion.
REQ-026 DONE SHALL last exactly one cycle with transfer=0 and the granted requester's ack=1, then return to IDLE.
REQ-027 Minimum latency SHALL be: grant edge to ack = 3 cycles (BUSY, BUSY, DONE).
REQ-028 Dropping req or changing command inputs during BUSY SHALL NOT affect the latched command; the transfer completes and ack is still issued.
REQ-029 A requester still high in the cycle after its ack SHALL be treated as a new request, subject to round-robin.
REQ-030 ack0 and ack1 SHALL never be high together, and SHALL never be high outside DONE.

Reset
REQ-031 PRESET high SHALL immediately force IDLE, transfer=0, READ_WRITE=0, all addresses/data=0, ack0=ack1=0, rdata=0, err=0, counter=0 and last-grant=requester 1 (so req0 wins the first tie).
REQ-032 Reset during BUSY SHALL abort silently with no ack; requesters re-request after reset deasserts.

Verification
REQ-033 Single write: req0=1, rw0=0, addr0=0x012, wdata0=0xA5, PREADY high at the 2nd BUSY cycle -> transfer=1 for 2 cycles, apb_write_paddr=0x012, apb_write_data=0xA5, ack0 pulse with err=0.
REQ-034 Read with wait states: req1=1, rw1=1, addr1=0x105, PREADY low for 3 BUSY cycles then high with apb_read_data_out=0x3C -> apb_read_paddr=0x105, ack1 pulse, rdata=0x3C, err=0.
REQ-035 Round-robin: req0 and req1 asserted together and held -> grant order 0,1,0,1 over four transfers, one ack per transfer.
REQ-036 Error and timeout: PSLVERR=1 in BUSY cycle 1 -> DONE next cycle with err=1. Separately, PREADY held low -> ack with err=1 after TIMEOUT BUSY cycles (15 by default).
REQ-037 Reset mid-transfer: assert PRESET in BUSY cycle 2 -> transfer=0 asynchronously, no ack. After release, a pending req0 is granted on the next edge.
